seq_divider: RTL and testbench

- Multi-cycle restoring integer divider for the pipeline's execute stage.
- Inverse of the adder datapath: one trial subtraction per cycle, producing one quotient bit per cycle.
- The pipeline stalls on busy and consumes the quotient/remainder when done pulses.
- Sits beside the ALU, sharing operand buses with it.

---
 rtl/div_pkg.sv | 25 ++
 rtl/div_step.sv | 33 +++
 rtl/seq_divider.sv | 210 +++++++++++++++++++++
 tb/tb_seq_divider.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared types and constants for the sequential restoring divider.
//   div_state_t   : controller states (IDLE, RUN, DONE)
//   DIV_WIDTH     : default operand width of seq_divider
//   DIV_CNT_W     : iteration counter width for the default operand width
//   div_cnt_width : counter width for an arbitrary operand width
// -----------------------------------------------------------------------------
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_WIDTH = 64;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    // The counter runs from width-1 down to 0, so $clog2(width) bits suffice.
    function automatic int div_cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage : div_pkg

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One iteration of a restoring divide: shift the next dividend bit into the
// partial remainder and attempt a subtraction of the divisor.
//   acc_i      : partial remainder from the previous step (always < divisor)
//   q_msb_i    : next dividend bit, taken from the quotient shift register MSB
//   divisor_i  : divisor magnitude
//   acc_o      : partial remainder after this step
//   q_bit_o    : quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] acc_i,
    input  logic             q_msb_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] acc_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] rem_shift;
    logic [WIDTH:0] diff;

    // The shifted remainder needs WIDTH+1 bits: acc < divisor, so 2*acc+1
    // can exceed WIDTH bits when the divisor's MSB is set.
    assign rem_shift = {acc_i, q_msb_i};
    assign diff      = rem_shift - {1'b0, divisor_i};

    // A clear borrow bit means the trial subtraction succeeded.
    assign q_bit_o = ~diff[WIDTH];
    assign acc_o   = q_bit_o ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];

endmodule : div_step

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Multi-cycle restoring integer divider for the execute stage. One quotient
// bit is produced per cycle; the pipeline stalls on busy and picks up the
// results in the cycle done pulses.
//
// Ports:
//   clk         : rising-edge clock
//   reset       : asynchronous, active-high; clears all state
//   start       : divide request, accepted only in IDLE
//   signed_op   : 1 = signed divide (only with DIV_SIGNED_EN)
//   dividend    : numerator, sampled on the accepted start
//   divisor     : denominator, sampled on the accepted start
//   busy        : high while iterating
//   done        : one-cycle pulse; results valid in that cycle
//   quotient    : result quotient, held until replaced by the next result
//   remainder   : result remainder, held until replaced by the next result
//   div_by_zero : set with done for a zero divisor, cleared on next start
//
// Configuration macro:
//   DIV_SIGNED_EN : when defined, signed_op selects a signed divide. Operands
//                   are converted to magnitudes on start and the sign fix-up
//                   is applied in the result register. When undefined,
//                   signed_op is ignored and all divides are unsigned.
//
// Latency: start accepted at edge N, done high after edge N+WIDTH+1
// (after edge N+1 for a zero divisor).
// -----------------------------------------------------------------------------
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = div_cnt_width(WIDTH);

    // Controller and datapath state
    div_state_t       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] acc_q;        // partial remainder
    logic [WIDTH-1:0] qsr_q;        // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] divisor_q;    // divisor magnitude
    logic [WIDTH-1:0] dividend_q;   // raw dividend, returned as remainder on divide-by-zero
    logic             zero_q;       // divisor was zero

    // Registered outputs
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rem_q;
    logic             dbz_q;

    // Single-step datapath outputs
    logic [WIDTH-1:0] acc_d;
    logic             q_bit_d;

    // Operand conditioning on start, and result fix-up on DONE
    logic [WIDTH-1:0] dividend_mag_d;
    logic [WIDTH-1:0] divisor_mag_d;
    logic [WIDTH-1:0] quot_fix_d;
    logic [WIDTH-1:0] rem_fix_d;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc_i     (acc_q),
        .q_msb_i   (qsr_q[WIDTH-1]),
        .divisor_i (divisor_q),
        .acc_o     (acc_d),
        .q_bit_o   (q_bit_d)
    );

`ifdef DIV_SIGNED_EN
    logic neg_quot_q;   // operand signs differ: negate the quotient
    logic neg_rem_q;    // dividend negative: negate the remainder
    logic neg_quot_d;
    logic neg_rem_d;

    // NOTE: every variable driven here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        dividend_mag_d = dividend;
        divisor_mag_d  = divisor;
        neg_quot_d     = 1'b0;
        neg_rem_d      = 1'b0;
        if (signed_op) begin
            // Negating the most-negative value wraps to itself, which is
            // already its correct unsigned magnitude.
            if (dividend[WIDTH-1]) dividend_mag_d = -dividend;
            if (divisor[WIDTH-1])  divisor_mag_d  = -divisor;
            neg_quot_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_rem_d  = dividend[WIDTH-1];
        end
    end

    assign quot_fix_d = neg_quot_q ? -qsr_q : qsr_q;
    assign rem_fix_d  = neg_rem_q  ? -acc_q : acc_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else if (state_q == IDLE && start) begin
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
        end
    end
`else
    // Unsigned-only build: signed_op has no effect.
    logic unused_signed_op;
    assign unused_signed_op = signed_op;

    assign dividend_mag_d = dividend;
    assign divisor_mag_d  = divisor;
    assign quot_fix_d     = qsr_q;
    assign rem_fix_d      = acc_q;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            qsr_q      <= '0;
            divisor_q  <= '0;
            dividend_q <= '0;
            zero_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            quot_q     <= '0;
            rem_q      <= '0;
            dbz_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        dividend_q <= dividend;
                        divisor_q  <= divisor_mag_d;
                        acc_q      <= '0;
                        qsr_q      <= dividend_mag_d;
                        cnt_q      <= CNT_W'(WIDTH - 1);
                        dbz_q      <= 1'b0;
                        if (divisor == '0) begin
                            zero_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            zero_q  <= 1'b0;
                            busy_q  <= 1'b1;
                            state_q <= RUN;
                        end
                    end
                end

                RUN: begin
                    acc_q <= acc_d;
                    qsr_q <= {qsr_q[WIDTH-2:0], q_bit_d};
                    if (cnt_q == '0) begin
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end

                DONE: begin
                    // Results land in the output registers together with
                    // the done pulse and stay put until the next result.
                    if (zero_q) begin
                        quot_q <= '1;
                        rem_q  <= dividend_q;
                        dbz_q  <= 1'b1;
                    end else begin
                        quot_q <= quot_fix_d;
                        rem_q  <= rem_fix_d;
                        dbz_q  <= 1'b0;
                    end
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule : seq_divider

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
// Scoreboard bench for seq_divider (WIDTH = 64). Each accepted divide pushes
// its expected result, computed with plain SystemVerilog arithmetic, into a
// queue; a monitor pops and compares whenever done is seen. Honours
// DIV_SIGNED_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_seq_divider;

    localparam int W = 64;
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int unsigned  done_cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         signed_op = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int unsigned  cyc = 0;
    int           n_checks = 0;
    int           n_pass = 0;
    exp_t         sb[$];

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .signed_op   (signed_op),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: integer division semantics straight from the arithmetic rules.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t e;
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sb_;
        sa = a;
        sb_ = b;
        e.dbz = 1'b0;
        e.done_cyc = 0;
        if (b == 0) begin
            e.q = '1;
            e.r = a;
            e.dbz = 1'b1;
        end else begin
            e.q = a / b;
            e.r = a % b;
`ifdef DIV_SIGNED_EN
            if (s) begin
                if (a == MIN_NEG && b == '1) begin
                    e.q = MIN_NEG;
                    e.r = '0;
                end else begin
                    e.q = sa / sb_;
                    e.r = sa % sb_;
                end
            end
`endif
        end
        return e;
    endfunction

    // Monitor: compares every done pulse against the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1'b1, 1'b0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quotient",    quotient,    e.q);
                check("remainder",   remainder,   e.r);
                check("div_by_zero", div_by_zero, e.dbz);
                check("done_cycle",  cyc,         e.done_cyc);
            end
        end
    end

    // Drive one start request; returns the edge number at which it was sampled.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         output int unsigned acc_cyc);
        @(negedge clk);
        dividend  = a;
        divisor   = b;
        signed_op = s;
        start     = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        start   = 1'b0;
    endtask

    task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                            input int unsigned acc_cyc);
        exp_t e;
        e = model(a, b, s);
        e.done_cyc = acc_cyc + ((b == 0) ? 1 : W + 1);
        sb.push_back(e);
    endtask

    // Wait (bounded) for done, counting busy cycles seen on the way.
    task automatic wait_done(output int busy_cycles);
        bit seen;
        seen = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < W + 20; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_cycles++;
        end
        if (!seen) check("done_timeout", 1'b0, 1'b1);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        int unsigned acc_cyc;
        int          bc;
        issue(a, b, s, acc_cyc);
        push_exp(a, b, s, acc_cyc);
        wait_done(bc);
        if (b != 0) check("busy_cycles", bc, W);
    endtask

    initial begin
        int unsigned acc_cyc;
        int          bc;
        logic [W-1:0] a;
        logic [W-1:0] b;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy",      busy,        1'b0);
        check("rst_done",      done,        1'b0);
        check("rst_quotient",  quotient,    '0);
        check("rst_remainder", remainder,   '0);
        check("rst_dbz",       div_by_zero, 1'b0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Directed cases
        run_op(64'd100, 64'd7, 1'b0);
        run_op(64'h1234, 64'd0, 1'b0);
        run_op('1, 64'd1, 1'b0);
        run_op(64'd5, 64'd9, 1'b0);
        run_op(-64'sd100, 64'd7, 1'b1);
        run_op(MIN_NEG, '1, 1'b1);
        run_op(-64'sd100, 64'd0, 1'b1);
        run_op(64'd100, -64'sd7, 1'b1);

        // Results hold through idle cycles and dbz clears on the next result
        repeat (10) @(negedge clk);
        check("hold_dbz", div_by_zero, 1'b0);
        run_op(64'd1000, 64'd10, 1'b0);
        repeat (7) @(negedge clk);
        check("hold_quotient",  quotient,  64'd100);
        check("hold_remainder", remainder, 64'd0);

        // Start while busy is ignored: one done, first result intact
        issue(64'd100, 64'd7, 1'b0, acc_cyc);
        push_exp(64'd100, 64'd7, 1'b0, acc_cyc);
        repeat (5) @(negedge clk);
        dividend = 64'd100;
        divisor  = 64'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(bc);
        repeat (W + 10) @(negedge clk);
        check("busy_start_quotient", quotient, 64'd14);

        // Reset mid-run: outputs cleared, no done, then a clean divide
        issue(64'd100, 64'd7, 1'b0, acc_cyc);
        repeat (30) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_busy",      busy,      1'b0);
        check("midrst_quotient",  quotient,  '0);
        check("midrst_remainder", remainder, '0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (W + 10) @(negedge clk);
        check("midrst_no_done", quotient, '0);
        run_op(64'd100, 64'd7, 1'b0);

        // Randomised patterns
        for (int i = 0; i < 40; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case ($urandom_range(0, 4))
                0: ;
                1: b = W'($urandom_range(1, 15));
                2: b = '0;
                3: begin a = W'($urandom_range(0, 1000)); b = a + W'($urandom_range(1, 50)); end
                default: b[W-1] = 1'b1;
            endcase
            run_op(a, b, 1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_seq_divider
